// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin IF/DM arbiter onto one BIU port,
// with locked DM sequences and an in-order response owner FIFO.
module riscv_mem_arbiter #(
  parameter int  XLEN        = 32,
  parameter int  MAX_PENDING = 2,
  parameter type biu_size_t  = logic [1:0]
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  input  biu_size_t       if_size_i,
  output logic            if_ack_o,
  output logic            if_rsp_o,
  input  logic            dm_req_i,
  input  logic [XLEN-1:0] dm_adr_i,
  input  biu_size_t       dm_size_i,
  input  logic            dm_lock_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_d_i,
  output logic            dm_ack_o,
  output logic            dm_rsp_o,
  output logic [XLEN-1:0] q_o,
  output logic            err_o,
  output logic            req_o,
  output logic [XLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output logic            we_o,
  output logic [XLEN-1:0] d_o,
  input  logic            ack_i,
  input  logic            rsp_i,
  input  logic [XLEN-1:0] q_i,
  input  logic            err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_n;
  logic                   r_owner;
  logic                   r_last;
  logic                   w_own;
  logic                   w_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_lock;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_n;
  logic [CW-1:0]          w_wi;
  logic [MAX_PENDING-1:0] r_fifo;
  logic [MAX_PENDING-1:0] w_fifo_n;

  assign w_full = (r_cnt == CW'(MAX_PENDING));

  always_comb begin
    w_req = 1'b0;
    w_own = r_owner;
    if (!rst_i && !clr_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_full && (if_req_i || dm_req_i)) begin
            w_req = 1'b1;
            if (if_req_i && dm_req_i) w_own = ~r_last;
            else w_own = dm_req_i;
          end
        end
        S_BUSY: w_req = 1'b1;
        S_LOCK: begin
          w_own = OWN_DM;
          w_req = !w_full && dm_req_i;
        end
        default: ;
      endcase
    end
  end

  assign w_push = w_req & ack_i;
  assign w_pop  = rsp_i & (r_cnt != '0) & ~clr_i & ~rst_i;
  assign w_lock = w_own & dm_lock_i;

  assign req_o  = w_req;
  assign adr_o  = !w_req ? '0 : (w_own ? dm_adr_i : if_adr_i);
  assign size_o = !w_req ? '0 : (w_own ? dm_size_i : if_size_i);
  assign lock_o = w_req & w_lock;
  assign we_o   = w_req & w_own & dm_we_i;
  assign d_o    = (w_req && w_own) ? dm_d_i : '0;

  assign if_ack_o = w_push & ~w_own;
  assign dm_ack_o = w_push & w_own;
  assign if_rsp_o = w_pop & ~r_fifo[0];
  assign dm_rsp_o = w_pop & r_fifo[0];
  assign q_o      = q_i;
  assign err_o    = err_i;

  // Owner FIFO as a shift register: head at bit 0
  always_comb begin
    w_wi     = r_cnt - CW'(w_pop);
    w_cnt_n  = r_cnt + CW'(w_push) - CW'(w_pop);
    w_fifo_n = w_pop ? (r_fifo >> 1) : r_fifo;
    for (int i = 0; i < MAX_PENDING; i++) begin
      if (w_push && (w_wi == CW'(i))) w_fifo_n[i] = w_own;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_push) w_state_n = w_lock ? S_LOCK : S_IDLE;
    else if (w_req) w_state_n = S_BUSY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_owner <= OWN_IF;
      r_last  <= OWN_IF;
      r_cnt   <= '0;
      r_fifo  <= '0;
    end else if (clr_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fifo  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_fifo  <= w_fifo_n;
      if (w_req) r_owner <= w_own;
      if (w_push) r_last <= w_own;
    end
  end

endmodule
